// File: rtl/register_file_param.sv
// ---------------------------------------------------------------------------
// register_file_param
//   Parametrised general-purpose register file. It has two combinational read
//   ports and one write port. A synchronous reset starts a clear sweep that
//   writes zero to one entry per cycle. The ready flag rises when the sweep
//   finishes. Options:
//     ZERO_REG = 1 : register 0 is hardwired to zero and writes to it are
//                    dropped.
//     BYPASS   = 1 : a read of the entry being written in the same cycle
//                    returns writeData instead of the stored value.
//
// Ports
//   clk          in   1      clock, all state changes on posedge
//   rst          in   1      synchronous, active-high reset
//   readAdr1     in   ADR_W  read port 1 address
//   readAdr2     in   ADR_W  read port 2 address
//   writeAdr     in   ADR_W  write address
//   writeData    in   WIDTH  write data
//   writeEnable  in   1      write request, sampled on posedge clk
//   readData1    out  WIDTH  read port 1 data (combinational)
//   readData2    out  WIDTH  read port 2 data (combinational)
//   ready        out  1      clear sweep done, writes accepted
//   wrDropped    out  1      registered pulse: previous cycle's write discarded
// ---------------------------------------------------------------------------
module register_file_param #(
    parameter int WIDTH    = 64,
    parameter int ADR_W    = 6,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] readAdr1,
    input  logic [ADR_W-1:0] readAdr2,
    input  logic [ADR_W-1:0] writeAdr,
    input  logic [WIDTH-1:0] writeData,
    input  logic             writeEnable,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    output logic             ready,
    output logic             wrDropped
);

    localparam int                 DEPTH    = 2 ** ADR_W;
    localparam logic [ADR_W-1:0]   LAST_ADR = ADR_W'(DEPTH - 1);
    localparam logic [ADR_W-1:0]   ADR_ZERO = ADR_W'(0);
    localparam logic [WIDTH-1:0]   DATA_ZERO = WIDTH'(0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [ADR_W-1:0] clr_ptr_q;
    logic [ADR_W-1:0] clr_ptr_d;
    logic             wr_dropped_q;
    logic             wr_dropped_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             zero_hit_s;
    logic             mem_we_s;
    logic [ADR_W-1:0] mem_wadr_s;
    logic [WIDTH-1:0] mem_wdata_s;
    logic [ADR_W-1:0] rd_adr_s  [2];
    logic [WIDTH-1:0] rd_data_s [2];

    // A write that targets the hardwired-zero entry is never stored.
    assign zero_hit_s = (ZERO_REG != 0) && (writeAdr == ADR_ZERO);

    // Next-state logic: sweep pointer advance, sweep exit and drop detection.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        wr_dropped_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == LAST_ADR) begin
                    state_d = ST_RUN;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADR_W'(1);
                end
                wr_dropped_d = writeEnable;
            end
            ST_RUN: begin
                wr_dropped_d = writeEnable && zero_hit_s;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = ADR_ZERO;
            end
        endcase
    end

    // Control registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= ADR_ZERO;
            wr_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            wr_dropped_q <= wr_dropped_d;
        end
    end

    // Storage write-port mux: sweep clears take the port during CLEAR, user
    // writes only in RUN. Nothing is written on a reset edge.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_wadr_s  = writeAdr;
        mem_wdata_s = writeData;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_wadr_s  = clr_ptr_q;
            mem_wdata_s = DATA_ZERO;
        end else if (state_q == ST_RUN) begin
            mem_we_s = writeEnable && !zero_hit_s;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array, deliberately without reset (cleared by the sweep).
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_wadr_s] <= mem_wdata_s;
        end
    end

    assign rd_adr_s[0] = readAdr1;
    assign rd_adr_s[1] = readAdr2;

    // Read ports: zero during the sweep, then zero-reg rule, bypass, storage.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_s[p] = DATA_ZERO;
            if (state_q != ST_RUN) begin
                rd_data_s[p] = DATA_ZERO;
            end else if ((ZERO_REG != 0) && (rd_adr_s[p] == ADR_ZERO)) begin
                rd_data_s[p] = DATA_ZERO;
            end else if ((BYPASS != 0) && writeEnable && (writeAdr == rd_adr_s[p])) begin
                rd_data_s[p] = writeData;
            end else begin
                rd_data_s[p] = mem_q[rd_adr_s[p]];
            end
        end
    end

    assign readData1 = rd_data_s[0];
    assign readData2 = rd_data_s[1];
    assign ready     = (state_q == ST_RUN);
    assign wrDropped = wr_dropped_q;

endmodule

// File: tb/tb_register_file_param.sv
// ---------------------------------------------------------------------------
// tb_register_file_param
//   Drives a default instance (64x64, zero reg, bypass) and a small variant
//   (8x32, no zero reg, no bypass) side by side. Each one is compared against
//   a behavioural model that tracks the remaining sweep length and the
//   register contents as plain arrays.
// ---------------------------------------------------------------------------
module tb_register_file_param;

    logic        clk = 1'b0;
    logic        rst;

    logic [5:0]  ra1_0, ra2_0, wa_0;
    logic [63:0] wd_0;
    logic        we_0;
    logic [63:0] rd1_0, rd2_0;
    logic        rdy_0, drop_0;

    logic [2:0]  ra1_1, ra2_1, wa_1;
    logic [31:0] wd_1;
    logic        we_1;
    logic [31:0] rd1_1, rd2_1;
    logic        rdy_1, drop_1;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [63:0] m0_mem [64];
    int          m0_left;
    logic        m0_drop;
    logic [31:0] m1_mem [8];
    int          m1_left;
    logic        m1_drop;

    always #5 clk = ~clk;

    register_file_param dut0 (
        .clk(clk), .rst(rst),
        .readAdr1(ra1_0), .readAdr2(ra2_0), .writeAdr(wa_0),
        .writeData(wd_0), .writeEnable(we_0),
        .readData1(rd1_0), .readData2(rd2_0),
        .ready(rdy_0), .wrDropped(drop_0)
    );

    register_file_param #(.WIDTH(32), .ADR_W(3), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst),
        .readAdr1(ra1_1), .readAdr2(ra2_1), .writeAdr(wa_1),
        .writeData(wd_1), .writeEnable(we_1),
        .readData1(rd1_1), .readData2(rd2_1),
        .ready(rdy_1), .wrDropped(drop_1)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected read of the default instance.
    function automatic logic [63:0] exp0(input logic [5:0] a);
        if (m0_left != 0) return 64'd0;
        if (a == 6'd0) return 64'd0;
        if (we_0 && (wa_0 == a)) return wd_0;
        return m0_mem[a];
    endfunction

    // Expected read of the variant: no zero reg, no bypass.
    function automatic logic [63:0] exp1(input logic [2:0] a);
        if (m1_left != 0) return 64'd0;
        return {32'd0, m1_mem[a]};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m0_left = 64;
            m0_drop = 1'b0;
            m1_left = 8;
            m1_drop = 1'b0;
            for (int i = 0; i < 64; i++) m0_mem[i] = 64'd0;
            for (int i = 0; i < 8; i++)  m1_mem[i] = 32'd0;
        end else begin
            m0_drop = we_0 && ((m0_left != 0) || (wa_0 == 6'd0));
            if ((m0_left == 0) && we_0 && (wa_0 != 6'd0)) m0_mem[wa_0] = wd_0;
            if (m0_left > 0) m0_left--;
            m1_drop = we_1 && (m1_left != 0);
            if ((m1_left == 0) && we_1) m1_mem[wa_1] = wd_1;
            if (m1_left > 0) m1_left--;
        end
    endtask

    // Let inputs settle, then compare every output with the model.
    task automatic settle();
        #1;
        check_val("rdy0",  {63'd0, rdy_0},  {63'd0, (m0_left == 0)});
        check_val("drop0", {63'd0, drop_0}, {63'd0, m0_drop});
        check_val("rd1_0", rd1_0, exp0(ra1_0));
        check_val("rd2_0", rd2_0, exp0(ra2_0));
        check_val("rdy1",  {63'd0, rdy_1},  {63'd0, (m1_left == 0)});
        check_val("drop1", {63'd0, drop_1}, {63'd0, m1_drop});
        check_val("rd1_1", {32'd0, rd1_1}, exp1(ra1_1));
        check_val("rd2_1", {32'd0, rd2_1}, exp1(ra2_1));
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        ra1_0 = 6'd0; ra2_0 = 6'd0; wa_0 = 6'd0; wd_0 = 64'd0; we_0 = 1'b0;
        ra1_1 = 3'd0; ra2_1 = 3'd0; wa_1 = 3'd0; wd_1 = 32'd0; we_1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt0, cnt1, guard, drops;
        idle_inputs();
        m0_left = 64; m1_left = 8; m0_drop = 1'b0; m1_drop = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Test 1: single-cycle reset, sweep length, all entries zero.
        clock_edge();
        rst = 1'b0;
        cnt0 = 0; cnt1 = 0; guard = 0;
        settle();
        check_val("rst_rdy0",  {63'd0, rdy_0}, 64'd0);
        check_val("rst_drop0", {63'd0, drop_0}, 64'd0);
        while (!((rdy_0 === 1'b1) && (rdy_1 === 1'b1)) && (guard < 200)) begin
            if (rdy_0 !== 1'b1) cnt0++;
            if (rdy_1 !== 1'b1) cnt1++;
            clock_edge();
            settle();
            guard++;
        end
        check_val("sweep_len0", 64'(cnt0), 64'd64);
        check_val("sweep_len1", 64'(cnt1), 64'd8);
        clock_edge();
        for (int i = 0; i < 64; i++) begin
            ra1_0 = 6'(i); ra2_0 = 6'(63 - i);
            ra1_1 = 3'(i); ra2_1 = 3'(7 - (i % 8));
            settle();
            check_val("sweep_rd0", rd1_0, 64'd0);
            clock_edge();
        end

        // Test 2: write r5, read it back next cycle, neighbour stays zero.
        we_0 = 1'b1; wa_0 = 6'd5; wd_0 = 64'hDEAD_BEEF_0123_4567;
        settle();
        clock_edge();
        we_0 = 1'b0; ra1_0 = 6'd5; ra2_0 = 6'd6;
        settle();
        check_val("wr_rd5", rd1_0, 64'hDEAD_BEEF_0123_4567);
        check_val("wr_rd6", rd2_0, 64'd0);
        clock_edge();

        // Test 3: same-cycle bypass on port 2.
        we_0 = 1'b1; wa_0 = 6'd7; ra2_0 = 6'd7; wd_0 = 64'h1234;
        settle();
        check_val("bypass", rd2_0, 64'h1234);
        clock_edge();

        // Test 4: writes to r0 are dropped and flagged for one cycle.
        we_0 = 1'b1; wa_0 = 6'd0; wd_0 = 64'hFF; ra1_0 = 6'd0;
        settle();
        check_val("zero_rd_same", rd1_0, 64'd0);
        clock_edge();
        we_0 = 1'b0;
        settle();
        check_val("zero_drop_hi", {63'd0, drop_0}, 64'd1);
        check_val("zero_rd_after", rd1_0, 64'd0);
        clock_edge();
        settle();
        check_val("zero_drop_lo", {63'd0, drop_0}, 64'd0);
        clock_edge();

        // Test 5: reset again mid-sweep, write during CLEAR is dropped.
        rst = 1'b1;
        settle();
        clock_edge();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            clock_edge();
        end
        rst = 1'b1;
        we_0 = 1'b1; wa_0 = 6'd4; wd_0 = 64'd77;
        settle();
        clock_edge();
        rst = 1'b0;
        settle();
        check_val("rst_wins_drop", {63'd0, drop_0}, 64'd0);
        we_0 = 1'b1; wa_0 = 6'd3; wd_0 = 64'd9;
        cnt0 = 0; drops = 0; guard = 0;
        while ((rdy_0 !== 1'b1) && (guard < 200)) begin
            cnt0++;
            if (drop_0 === 1'b1) drops++;
            clock_edge();
            we_0 = 1'b0;
            settle();
            guard++;
        end
        check_val("resweep_len", 64'(cnt0), 64'd64);
        check_val("resweep_drops", 64'(drops), 64'd1);
        clock_edge();
        ra1_0 = 6'd3; ra2_0 = 6'd4;
        settle();
        check_val("resweep_r3", rd1_0, 64'd0);
        check_val("resweep_r4", rd2_0, 64'd0);
        clock_edge();

        // Test 6: variant stores r0 and has no bypass.
        we_1 = 1'b1; wa_1 = 3'd0; wd_1 = 32'hA5A5;
        settle();
        clock_edge();
        we_1 = 1'b0; ra1_1 = 3'd0;
        settle();
        check_val("var_r0", {32'd0, rd1_1}, 64'h0000_0000_0000_A5A5);
        check_val("var_nodrop", {63'd0, drop_1}, 64'd0);
        clock_edge();
        we_1 = 1'b1; wa_1 = 3'd2; wd_1 = 32'h1111;
        settle();
        clock_edge();
        we_1 = 1'b1; wa_1 = 3'd2; wd_1 = 32'h2222; ra1_1 = 3'd2;
        settle();
        check_val("var_old", {32'd0, rd1_1}, 64'h1111);
        clock_edge();
        we_1 = 1'b0;
        settle();
        check_val("var_new", {32'd0, rd1_1}, 64'h2222);
        clock_edge();

        // Randomised phase with occasional resets, checked every cycle.
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 149) == 0);
            we_0  = $urandom_range(0, 1) == 1;
            wa_0  = 6'($urandom_range(0, 63));
            wd_0  = {32'($urandom), 32'($urandom)};
            ra1_0 = ($urandom_range(0, 3) == 0) ? wa_0 : 6'($urandom_range(0, 63));
            ra2_0 = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            we_1  = $urandom_range(0, 1) == 1;
            wa_1  = 3'($urandom_range(0, 7));
            wd_1  = 32'($urandom);
            ra1_1 = ($urandom_range(0, 3) == 0) ? wa_1 : 3'($urandom_range(0, 7));
            ra2_1 = 3'($urandom_range(0, 7));
            settle();
            clock_edge();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
